// File: rtl/vsh_pkg.sv
// Shared types and defaults for the vector signature harness.
package vsh_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [35:0] DEF_LFSR_POLY = 36'h0_0000_0801;
  localparam logic [35:0] DEF_LFSR_SEED = 36'h0_0000_0001;
  localparam logic [15:0] DEF_MISR_POLY = 16'h1021;
  localparam logic [15:0] DEF_MISR_SEED = 16'h0000;

  localparam logic MODE_LFSR = 1'b0;
  localparam logic MODE_EXT  = 1'b1;

endpackage

// File: rtl/galois_lfsr.sv
// Galois shift register with parallel load; din folds data in, so the same
// block serves as a pattern generator (din=0) or as a MISR.
module galois_lfsr #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   POLY = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_nxt;

  assign q_nxt = {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= seed;
    else if (en)   q <= q_nxt;
  end

endmodule

// File: rtl/vector_sig_harness.sv
// Drives a combinational/pipelined benchmark DUT with N vectors and compacts
// its responses into a MISR signature that is compared against a golden value.
module vector_sig_harness
  import vsh_pkg::*;
#(
  parameter int                IN_W      = 36,
  parameter int                OUT_W     = 7,
  parameter int                SIG_W     = 16,
  parameter int                CNT_W     = 16,
  parameter int                DUT_LAT   = 0,
  parameter logic [IN_W-1:0]   LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [IN_W-1:0]   LFSR_SEED = DEF_LFSR_SEED,
  parameter logic [SIG_W-1:0]  MISR_POLY = DEF_MISR_POLY,
  parameter logic [SIG_W-1:0]  MISR_SEED = DEF_MISR_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [IN_W-1:0]   ext_vec,
  input  logic              ext_valid,
  output logic              ext_ready,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  input  logic [SIG_W-1:0]  gold_sig,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic              sig_match,
  output logic [CNT_W-1:0]  vec_count
);

  localparam int              PIPE_W     = DUT_LAT + 1;
  // Stages younger than the capture stage; DRAIN ends once these are empty.
  localparam logic [PIPE_W-1:0] LOWER_MASK = PIPE_W'((1 << DUT_LAT) - 1);

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] d);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : '0) ^ d;
  endfunction

  state_t              state, state_nxt;
  logic                mode_q;
  logic [CNT_W-1:0]    num_q;
  logic [PIPE_W-1:0]   vld_pipe;
  logic [IN_W-1:0]     lfsr_q;
  logic [SIG_W-1:0]    resp_ext;
  logic                start_ok, issue, last_issue, cap, drain_done;

  assign start_ok   = (state == IDLE) && start;
  assign ext_ready  = (state == RUN) && (mode_q == MODE_EXT);
  assign issue      = (state == RUN) && ((mode_q == MODE_LFSR) || ext_valid);
  assign last_issue = issue && ((vec_count + CNT_W'(1)) == num_q);
  assign cap        = vld_pipe[DUT_LAT];
  assign drain_done = (state == DRAIN) && cap && ((vld_pipe & LOWER_MASK) == '0);
  assign busy       = (state != IDLE);
  assign resp_ext   = SIG_W'(dut_out);

  galois_lfsr #(.W(IN_W), .POLY(LFSR_POLY)) u_vec_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  (LFSR_SEED),
    .en    (issue && (mode_q == MODE_LFSR)),
    .din   ('0),
    .q     (lfsr_q)
  );

  galois_lfsr #(.W(SIG_W), .POLY(MISR_POLY)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  (MISR_SEED),
    .en    (cap),
    .din   (resp_ext),
    .q     (signature)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (num_vec != '0)) state_nxt = RUN;
      RUN:     if (last_issue)               state_nxt = DRAIN;
      DRAIN:   if (drain_done)               state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Issue stage feeds dut_in; valid travels down vld_pipe to the capture point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_LFSR;
      num_q     <= '0;
      vec_count <= '0;
      done      <= 1'b0;
      sig_match <= 1'b0;
      dut_in    <= '0;
      vld_pipe  <= '0;
    end else begin
      done     <= 1'b0;
      vld_pipe <= (vld_pipe << 1) | PIPE_W'(issue);
      if (start_ok) begin
        mode_q    <= mode;
        num_q     <= num_vec;
        vec_count <= '0;
        sig_match <= 1'b0;
        if (num_vec == '0) begin
          done      <= 1'b1;
          sig_match <= (MISR_SEED == gold_sig);
        end
      end
      if (issue) begin
        dut_in    <= (mode_q == MODE_LFSR) ? lfsr_q : ext_vec;
        vec_count <= vec_count + CNT_W'(1);
      end
      // Compare against the value the MISR takes on this same edge.
      if (drain_done) begin
        done      <= 1'b1;
        sig_match <= (misr_step(signature, resp_ext) == gold_sig);
      end
    end
  end

endmodule

// File: tb/tb_vector_sig_harness.sv
// Bench for vector_sig_harness: directed and randomized runs on a zero-latency
// instance (with optional tamper) and a two-stage pipelined instance.
module tb_vector_sig_harness;

  localparam logic [35:0] POLY36 = 36'h0_0000_0801;
  localparam logic [35:0] SEED36 = 36'h0_0000_0001;
  localparam logic [15:0] POLY16 = 16'h1021;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit tamper = 1'b0;

  // Instance A: combinational stub, optional single-bit tamper on vector 8
  logic        start_a = 0, mode_a = 0, ext_valid_a = 0;
  logic [15:0] num_a = 0, gold_a = 0;
  logic [35:0] ext_vec_a = 0;
  logic        ext_ready_a, busy_a, done_a, sig_match_a;
  logic [35:0] dut_in_a;
  logic [6:0]  dut_out_a;
  logic [15:0] sig_a, vec_count_a;

  assign dut_out_a = dut_in_a[6:0] ^ {6'b0, (tamper && (dut_in_a == 36'd8))};

  vector_sig_harness u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .num_vec(num_a),
    .ext_vec(ext_vec_a), .ext_valid(ext_valid_a), .ext_ready(ext_ready_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .gold_sig(gold_a), .busy(busy_a),
    .done(done_a), .signature(sig_a), .sig_match(sig_match_a), .vec_count(vec_count_a)
  );

  // Instance B: DUT modelled as two register stages
  logic        start_b = 0, mode_b = 0, ext_valid_b = 0;
  logic [15:0] num_b = 0, gold_b = 0;
  logic [35:0] ext_vec_b = 0;
  logic        ext_ready_b, busy_b, done_b, sig_match_b;
  logic [35:0] dut_in_b;
  logic [6:0]  s1_b, s2_b;
  logic [15:0] sig_b, vec_count_b;

  always @(posedge clk) begin
    s1_b <= dut_in_b[6:0];
    s2_b <= s1_b;
  end

  vector_sig_harness #(.DUT_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .num_vec(num_b),
    .ext_vec(ext_vec_b), .ext_valid(ext_valid_b), .ext_ready(ext_ready_b),
    .dut_in(dut_in_b), .dut_out(s2_b), .gold_sig(gold_b), .busy(busy_b),
    .done(done_b), .signature(sig_b), .sig_match(sig_match_b), .vec_count(vec_count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Multiplication by x modulo x^36+x^11+1.
  function automatic logic [35:0] lfsr_model(input logic [35:0] v);
    return (v << 1) ^ (v[35] ? POLY36 : 36'd0);
  endfunction

  // Signature polynomial: s*x + response, reduced modulo the MISR polynomial.
  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [35:0] v, input bit t);
    logic [6:0] r;
    r = v[6:0] ^ {6'b0, (t && (v == 36'd8))};
    return (s << 1) ^ (s[15] ? POLY16 : 16'd0) ^ {9'd0, r};
  endfunction

  // Expected signature after the first n LFSR vectors.
  function automatic logic [15:0] lfsr_sig(input int n, input bit t);
    logic [35:0] v;
    logic [15:0] s;
    v = SEED36;
    s = 16'd0;
    for (int i = 0; i < n; i++) begin
      s = misr_model(s, v, t);
      v = lfsr_model(v);
    end
    return s;
  endfunction

  task automatic run_a(input string tag, input logic m, input int n,
                       input logic [15:0] gold, input int vpat);
    logic [35:0] q[$];
    logic [35:0] v;
    logic [15:0] es;
    int e, bound;
    bit seen, drain_chk;
    mode_a = m;
    num_a = 16'(n);
    gold_a = gold;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    if (n == 0) chk({tag, "_busy0"}, 64'(busy_a), 64'd0);
    e = 0;
    seen = done_a;
    bound = 4 * n + 20;
    drain_chk = 0;
    while (!seen && e < bound) begin
      if (m) begin
        if (q.size() == n && !drain_chk) begin
          chk({tag, "_rdy_drain"}, 64'(ext_ready_a), 64'd0);
          drain_chk = 1;
        end
        ext_valid_a = (vpat == 1) ? (e % 2 == 0) : 1'($urandom_range(0, 1));
        ext_vec_a = 36'({$urandom(), $urandom()});
        if (ext_valid_a && ext_ready_a) q.push_back(ext_vec_a);
      end
      tick();
      e++;
      seen = done_a;
    end
    ext_valid_a = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (!m) begin
      v = SEED36;
      repeat (n) begin
        q.push_back(v);
        v = lfsr_model(v);
      end
      chk({tag, "_latency"}, 64'(e), (n == 0) ? 64'd0 : 64'(n + 1));
    end else begin
      chk({tag, "_issued"}, 64'(q.size()), 64'(n));
    end
    es = 16'd0;
    foreach (q[i]) es = misr_model(es, q[i], tamper);
    chk({tag, "_vec_count"}, 64'(vec_count_a), 64'(n));
    chk({tag, "_sig"}, 64'(sig_a), 64'(es));
    chk({tag, "_match"}, 64'(sig_match_a), 64'(es == gold));
    chk({tag, "_busy_end"}, 64'(busy_a), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(done_a), 64'd0);
    chk({tag, "_sig_hold"}, 64'(sig_a), 64'(es));
  endtask

  initial begin
    bit done_any;
    logic [15:0] g;
    int e;

    // Reset state
    tick();
    chk("rst_dut_in", 64'(dut_in_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_sig", 64'(sig_a), 64'd0);
    chk("rst_match", 64'(sig_match_a), 64'd0);
    chk("rst_cnt", 64'(vec_count_a), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: LFSR, N=4, per-edge timing
    mode_a = 1'b0; num_a = 16'd4; gold_a = 16'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t1_busy", 64'(busy_a), 64'd1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 4) chk("t1_dut_in", 64'(dut_in_a), 64'd1 << (k - 1));
      if (k == 2) chk("t1_first_sig", 64'(sig_a), 64'h0001);
      chk("t1_done", 64'(done_a), 64'(k == 5));
    end
    chk("t1_sig", 64'(sig_a), 64'(lfsr_sig(4, 0)));
    chk("t1_match", 64'(sig_match_a), 64'(lfsr_sig(4, 0) == 16'd0));
    chk("t1_dut_in_hold", 64'(dut_in_a), 64'd8);
    chk("t1_rdy_idle", 64'(ext_ready_a), 64'd0);

    // 2: zero-length runs
    run_a("t2a", 1'b0, 0, 16'h0000, 0);
    run_a("t2b", 1'b0, 0, 16'h1234, 0);

    // 3: external vectors with alternating valid
    run_a("t3", 1'b1, 3, 16'h0000, 1);
    chk("t3_rdy_idle", 64'(ext_ready_a), 64'd0);

    // 4: DUT_LAT=2, N=5: captures lag issue by three edges
    mode_b = 1'b0; num_b = 16'd5; gold_b = lfsr_sig(5, 0); start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      int ncap;
      tick();
      ncap = (k - 3 < 0) ? 0 : ((k - 3 > 5) ? 5 : k - 3);
      chk("t4_sig", 64'(sig_b), 64'(lfsr_sig(ncap, 0)));
      chk("t4_done", 64'(done_b), 64'(k == 8));
      if (k == 8) chk("t4_match", 64'(sig_match_b), 64'd1);
    end
    chk("t4_cnt", 64'(vec_count_b), 64'd5);

    // 5: golden compare, clean then tampered
    g = lfsr_sig(8, 0);
    run_a("t5_clean", 1'b0, 8, g, 0);
    chk("t5_clean_match", 64'(sig_match_a), 64'd1);
    tamper = 1'b1;
    run_a("t5_tamper", 1'b0, 8, g, 0);
    chk("t5_tamper_match", 64'(sig_match_a), 64'd0);
    tamper = 1'b0;

    // 6a: reset in the middle of a run
    mode_a = 1'b0; num_a = 16'd10; gold_a = 16'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dut_in", 64'(dut_in_a), 64'd0);
    chk("t6_rst_busy", 64'(busy_a), 64'd0);
    chk("t6_rst_sig", 64'(sig_a), 64'd0);
    chk("t6_rst_cnt", 64'(vec_count_a), 64'd0);
    chk("t6_rst_done", 64'(done_a), 64'd0);
    tick();
    rst_n = 1'b1;
    done_any = 0;
    repeat (14) begin
      tick();
      if (done_a) done_any = 1;
    end
    chk("t6_no_done", 64'(done_any), 64'd0);
    chk("t6_idle_busy", 64'(busy_a), 64'd0);

    // 6b: start while busy is ignored
    mode_a = 1'b0; num_a = 16'd6; gold_a = lfsr_sig(6, 0); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    mode_a = 1'b1; num_a = 16'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t6_busy_rdy", 64'(ext_ready_a), 64'd0);
    e = 2;
    while (!done_a && e < 30) begin
      tick();
      e++;
    end
    chk("t6_busy_latency", 64'(e), 64'd7);
    chk("t6_busy_cnt", 64'(vec_count_a), 64'd6);
    chk("t6_busy_sig", 64'(sig_a), 64'(lfsr_sig(6, 0)));
    chk("t6_busy_match", 64'(sig_match_a), 64'd1);
    tick();

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 20);
      g = (r % 2 == 0) ? lfsr_sig(n, 0) : 16'($urandom());
      run_a("rnd_lfsr", 1'b0, n, g, 0);
    end
    for (int r = 0; r < 3; r++) run_a("rnd_ext", 1'b1, $urandom_range(1, 10), 16'($urandom()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
